// File: rtl/inst_fetch_queue_pkg.sv
// Shared front-end definitions: RV32 major-opcode encodings (inst[6:2]),
// the fetch-queue entry type and a control-flow classifier used by predecode.
package inst_fetch_queue_pkg;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ifq_entry_t;

  // True for opcodes that can redirect the fetch stream.
  function automatic logic is_ctrl_opc(input logic [4:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode bus of the instruction fetch queue.
// master: fetch unit + decoders (drive in_*, out_take); slave: the queue.
// out_is_ctrl exists only when IFQ_PREDECODE_EN is defined.
interface inst_fetch_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    in_valid;
  logic [31:0]   in_inst0;
  logic [31:0]   in_inst1;
  logic [31:0]   in_pc;
  logic          in_ready;
  logic [1:0]    out_valid;
  logic [31:0]   out_inst0;
  logic [31:0]   out_inst1;
  logic [31:0]   out_pc0;
  logic [31:0]   out_pc1;
  logic [1:0]    out_take;
  logic [CW-1:0] count;
`ifdef IFQ_PREDECODE_EN
  logic [1:0]    out_is_ctrl;
`endif

  modport master (
    output in_valid, in_inst0, in_inst1, in_pc, out_take,
    input  in_ready, out_valid, out_inst0, out_inst1, out_pc0, out_pc1, count
`ifdef IFQ_PREDECODE_EN
    , input out_is_ctrl
`endif
  );

  modport slave (
    input  in_valid, in_inst0, in_inst1, in_pc, out_take,
    output in_ready, out_valid, out_inst0, out_inst1, out_pc0, out_pc1, count
`ifdef IFQ_PREDECODE_EN
    , output out_is_ctrl
`endif
  );

endinterface

// File: rtl/ifq_predecode.sv
// Combinational control-flow predecode for one decoder lane (JAL/JALR/BRANCH).
// Compiled only when IFQ_PREDECODE_EN is defined.
`ifdef IFQ_PREDECODE_EN
module ifq_predecode
  import inst_fetch_queue_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_ctrl
);
  // Only the major opcode matters for classification.
  logic unused_bits;
  assign unused_bits = ^{inst[31:7], inst[1:0]};
  assign is_ctrl     = is_ctrl_opc(inst[6:2]);
endmodule
`endif

// File: rtl/inst_fetch_queue.sv
// Dual-ported instruction fetch queue: up to two sequential instructions in,
// the two oldest entries out in program order, cleared by flush.
// Optional feature: IFQ_PREDECODE_EN adds out_is_ctrl and limits a decode
// bundle to one control-flow instruction placed last.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  inst_fetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifq_entry_t    mem [DEPTH];
  logic [AW-1:0] head, tail, head1, tail1;
  logic [CW-1:0] count;
  logic [1:0]    push_n, pop_n, occ, vld;
  ifq_entry_t    ent0, ent1;

  assign head1 = head + AW'(1);
  assign tail1 = tail + AW'(1);
  assign ent0  = mem[head];
  assign ent1  = mem[head1];

  // Acceptance looks at the current occupancy only; same-cycle pops give no credit.
  assign q.in_ready = (count <= CW'(DEPTH - 2));
  assign push_n     = (q.in_ready && q.in_valid[0]) ? (q.in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
  assign occ        = {count >= CW'(2), count != '0};

`ifdef IFQ_PREDECODE_EN
  logic [1:0] ctrl_raw;

  ifq_predecode u_pd0 (.inst(ent0.inst), .is_ctrl(ctrl_raw[0]));
  ifq_predecode u_pd1 (.inst(ent1.inst), .is_ctrl(ctrl_raw[1]));

  // A control-flow instruction in slot 0 closes the bundle.
  assign vld           = {occ[1] & ~(occ[0] & ctrl_raw[0]), occ[0]};
  assign q.out_is_ctrl = vld & ctrl_raw;
`else
  assign vld = occ;
`endif

  // Takes beyond the valid slots are ignored, and slot 1 needs slot 0.
  assign pop_n = {1'b0, q.out_take[0] & vld[0]} +
                 {1'b0, q.out_take[0] & q.out_take[1] & vld[1]};

  assign q.out_valid = vld;
  assign q.out_inst0 = vld[0] ? ent0.inst : '0;
  assign q.out_pc0   = vld[0] ? ent0.pc   : '0;
  assign q.out_inst1 = vld[1] ? ent1.inst : '0;
  assign q.out_pc1   = vld[1] ? ent1.pc   : '0;
  assign q.count     = count;

  // Pointer and occupancy control; flush overrides any same-cycle push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_n);
      tail  <= tail + AW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // Entry storage: slot 0 at tail, slot 1 at tail+1 with the next sequential PC.
  always_ff @(posedge clk) begin
    if (!flush && push_n != 2'd0) begin
      mem[tail] <= '{inst: q.in_inst0, pc: q.in_pc};
    end
    if (!flush && push_n == 2'd2) begin
      mem[tail1] <= '{inst: q.in_inst1, pc: q.in_pc + 32'd4};
    end
  end

endmodule
